apb_cmd_queue: RTL

APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

---
 rtl/apb_pkg.sv | 36 +++
 rtl/apb_sync_fifo.sv | 61 ++++++
 rtl/apb_cmd_queue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB command queue.
// The command record, FSM state encoding and default sizing live here so the
// queue and its storage agree on one layout.
package apb_pkg;

  localparam int APB_ADDR_W      = 9;
  localparam int APB_DATA_W      = 8;
  localparam int APB_DEPTH_DEF   = 4;
  localparam int APB_TIMEOUT_DEF = 16;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  localparam int APB_CMD_W = $bits(apb_cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

  // Assemble a command record from the host-side fields.
  function automatic apb_cmd_t make_cmd(input logic                  write,
                                        input logic [APB_ADDR_W-1:0] addr,
                                        input logic [APB_DATA_W-1:0] wdata);
    apb_cmd_t c;
    c.write = write;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/apb_sync_fifo.sv
// Single-clock FIFO holding queued APB commands.
// DEPTH must be a power of two so the pointers wrap naturally.
module apb_sync_fifo
  import apb_pkg::*;
#(
  parameter int DEPTH = APB_DEPTH_DEF,
  parameter int WIDTH = APB_CMD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_en_s;
  logic             pop_en_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_en_s = push && !full;
  assign pop_en_s  = pop && !empty;

  // Write the incoming command into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Advance pointers and track occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_en_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_en_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/apb_cmd_queue.sv
// Host command queue in front of an APB master: buffers commands, issues one
// at a time, and returns each completion through a response handshake.
// Optional BUSY watchdog compiled in with `define APB_CMD_TIMEOUT_EN.
module apb_cmd_queue
  import apb_pkg::*;
#(
  parameter int DEPTH          = APB_DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [8:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       transfer,
  output logic       read,
  output logic       write,
  output logic [8:0] apb_write_paddr,
  output logic [8:0] apb_read_paddr,
  output logic [7:0] apb_write_data,
  input  logic       m_done,
  input  logic [7:0] m_rdata,
  input  logic       m_slverr,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_write,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_cmd_queue: DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_e             state_r, next_state_s;
  apb_cmd_t               cmd_in_s, head_s, issue_cmd_s;
  logic [APB_CMD_W-1:0]   head_raw_s;
  logic                   push_s, pop_s, full_s, empty_s, timeout_s;
  logic [CNT_W-1:0]       count_s;
  logic                   transfer_r, read_r, write_r;
  logic [8:0]             paddr_r;
  logic [7:0]             wdata_r;
  logic                   rsp_valid_r, rsp_write_r, rsp_err_r;
  logic [7:0]             rsp_rdata_r;

  assign cmd_ready   = !full_s;
  assign push_s      = cmd_valid && !full_s;
  assign cmd_in_s    = make_cmd(cmd_write, cmd_addr, cmd_wdata);
  assign head_s      = apb_cmd_t'(head_raw_s);
  // An empty queue forwards the command being pushed so it issues next cycle.
  assign issue_cmd_s = empty_s ? cmd_in_s : head_s;
  assign pop_s       = (state_r == ST_BUSY) && (m_done || timeout_s);

  apb_sync_fifo #(.DEPTH(DEPTH), .WIDTH(APB_CMD_W)) u_fifo (
    .clk   (pclk),
    .rst   (preset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (cmd_in_s),
    .dout  (head_raw_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

`ifdef APB_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Count cycles spent in BUSY; held at zero elsewhere so each entry restarts it.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_BUSY) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

  assign timeout_s = (state_r == ST_BUSY) && !m_done &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state decode: issue when work exists, finish on completion, wait for host.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (push_s || count_s != {CNT_W{1'b0}}) next_state_s = ST_BUSY;
        else                                   next_state_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (m_done || timeout_s) next_state_s = ST_RESP;
        else                     next_state_s = ST_BUSY;
      end
      ST_RESP: begin
        if (rsp_ready) next_state_s = ST_IDLE;
        else           next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Master-side request registers: load on issue, drop strobes on completion.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      transfer_r <= 1'b0;
      read_r     <= 1'b0;
      write_r    <= 1'b0;
      paddr_r    <= 9'h000;
      wdata_r    <= 8'h00;
    end else if (state_r == ST_IDLE && next_state_s == ST_BUSY) begin
      transfer_r <= 1'b1;
      read_r     <= !issue_cmd_s.write;
      write_r    <= issue_cmd_s.write;
      paddr_r    <= issue_cmd_s.addr;
      wdata_r    <= issue_cmd_s.wdata;
    end else if (state_r == ST_BUSY && next_state_s == ST_RESP) begin
      transfer_r <= 1'b0;
      read_r     <= 1'b0;
      write_r    <= 1'b0;
    end
  end

  // Capture the completion into the response registers and hold until accepted.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
      rsp_err_r   <= 1'b0;
    end else if (pop_s) begin
      rsp_valid_r <= 1'b1;
      rsp_write_r <= write_r;
      if (m_done) begin
        rsp_rdata_r <= write_r ? 8'h00 : m_rdata;
        rsp_err_r   <= m_slverr;
      end else begin
        rsp_rdata_r <= 8'h00;
        rsp_err_r   <= 1'b1;
      end
    end else if (state_r == ST_RESP && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign transfer        = transfer_r;
  assign read            = read_r;
  assign write           = write_r;
  assign apb_write_paddr = paddr_r;
  assign apb_read_paddr  = paddr_r;
  assign apb_write_data  = wdata_r;
  assign rsp_valid       = rsp_valid_r;
  assign rsp_write       = rsp_write_r;
  assign rsp_rdata       = rsp_rdata_r;
  assign rsp_err         = rsp_err_r;

endmodule
